// File: rtl/if_stage_if.sv
// Bundles the instruction-memory port and the IF/ID outputs of the fetch stage.
// The master side is the fetch stage; the slave side is the memory and downstream.
interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_instruction;
  logic [31:0] id_pc_plus4;

  modport master (
    output imem_req, imem_addr, id_valid, id_instruction, id_pc_plus4,
    input  imem_gnt, imem_rvalid, imem_rdata, stall, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_instruction, id_pc_plus4,
    output imem_gnt, imem_rvalid, imem_rdata, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: single-outstanding imem requests, a small prefetch
// FIFO, and the IF/ID register feeding id_stage, with stall and redirect.
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  if_stage_if.master bus
);
  localparam int          PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef enum logic [1:0] {REQ, WAIT, DROP} state_e;

  state_e           state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      req_pc_q, req_pc_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             id_valid_q, id_valid_d;
  logic [31:0]      id_instr_q, id_instr_d;
  logic [31:0]      id_pc4_q, id_pc4_d;

  logic [31:0]      fifo_instr_q [FIFO_DEPTH];
  logic [31:0]      fifo_pc4_q   [FIFO_DEPTH];

  logic             fifo_full, fifo_empty;
  logic             req, push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);

  // Free-slot check at issue is what keeps the FIFO from ever overflowing.
  assign req = !rst && (state_q == REQ) && !fifo_full && !bus.redirect;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    id_valid_d = id_valid_q;
    id_instr_d = id_instr_q;
    id_pc4_d   = id_pc4_q;
    push       = 1'b0;
    pop        = 1'b0;

    if (bus.redirect) begin
      fetch_pc_d = bus.redirect_pc;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      id_valid_d = 1'b0;
      // An outstanding response must still be absorbed before fetching again.
      if (state_q != REQ) begin
        state_d = bus.imem_rvalid ? REQ : DROP;
      end
    end else begin
      unique case (state_q)
        REQ: begin
          if (req && bus.imem_gnt) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = WAIT;
          end
        end
        WAIT: begin
          if (bus.imem_rvalid) begin
            push    = 1'b1;
            state_d = REQ;
          end
        end
        DROP: begin
          if (bus.imem_rvalid) begin
            state_d = REQ;
          end
        end
        default: state_d = REQ;
      endcase

      if (!id_valid_q || !bus.stall) begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          id_instr_d = fifo_instr_q[rd_ptr_q];
          id_pc4_d   = fifo_pc4_q[rd_ptr_q];
          id_valid_d = 1'b1;
        end else begin
          id_valid_d = 1'b0;
        end
      end

      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= REQ;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      id_valid_q <= 1'b0;
      id_instr_q <= NOP;
      id_pc4_q   <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      id_valid_q <= id_valid_d;
      id_instr_q <= id_instr_d;
      id_pc4_q   <= id_pc4_d;
    end
  end

  // FIFO payload needs no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr_q[wr_ptr_q] <= bus.imem_rdata;
      fifo_pc4_q[wr_ptr_q]   <= req_pc_q + 32'd4;
    end
  end

  assign bus.imem_req       = req;
  assign bus.imem_addr      = fetch_pc_q;
  assign bus.id_valid       = id_valid_q;
  assign bus.id_instruction = id_instr_q;
  assign bus.id_pc_plus4    = id_pc4_q;
endmodule
